clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised, multi-channel successor to the fixed single-output clock divider. Generates, per channel, a single-cycle `tick` enable strobe and a 50%-duty `level` square wave from one system clock, with a runtime-loadable divide value, per-channel enable and synchronous clear. Sits beside the display/stopwatch timing logic; downstream logic uses `tick` as a clock enable on `clk`, never as a clock.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 16: counter and divide-value width.
- `DEFAULT_DIV`, default 200: terminal count loaded into every channel at reset; must fit in `CNT_W`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  CHANNELS  per-channel count enable; low freezes that channel.
- `clr`  in  CHANNELS  per-channel synchronous clear.
- `load`  in  CHANNELS  per-channel strobe: latch new terminal count.
- `div_val`  in  CHANNELS*CNT_W  terminal counts, channel i at bits [i*CNT_W +: CNT_W].
- `tick`  out  CHANNELS  one-cycle strobe per terminal count.
- `level`  out  CHANNELS  square wave, toggles at each terminal count.

## Operation
- Per-channel state: `cnt` (CNT_W), `term` (CNT_W, active terminal count), `tick` reg, `level` reg.
- Priority per channel, evaluated each rising edge: clr > load > en > idle.
- clr: `cnt`←0, `tick`←0, `level`←0; `term` unchanged.
- load (no clr): `term`←`div_val` slice, `cnt`←0, `tick`←0, `level` unchanged. Terminal coincident with load is discarded (no tick).
- en (no clr/load): if `cnt`==`term`: `cnt`←0, `tick`←1, `level`←~`level`; else `cnt`←`cnt`+1, `tick`←0.
- idle (en low): `cnt`, `level` hold; `tick`←0.
- Tick period = `term`+1 cycles; level period = 2·(`term`+1) cycles, exact 50% duty.
- `term`=0: tick high every enabled cycle; level toggles every cycle (clk/2).
- Counter never exceeds `term`; no wrap past 2^CNT_W−1 possible. Loading `term` below current `cnt` is safe because load zeroes `cnt`.
- Channels fully independent; no cross-channel state.

## Timing
- Reset (async assert, sync-to-clk release handled upstream): `cnt`=0, `term`=DEFAULT_DIV, `tick`=0, `level`=0 for all channels.
- Both outputs registered; no combinational path input→output.
- With `en` high from first edge after reset, first `tick` is high in the cycle after edge number `term`+1; `level` rises on that same edge.
- `load`/`clr` take effect on the edge they are sampled; next tick at earliest `term`+1 enabled edges later.
- Deasserting `en` for k cycles delays the next tick by exactly k cycles.
- Reset mid-count: outputs drop to reset values immediately (asynchronously).

## Structure
- Package `clk_div_pkg`: `CNT_W_DEFAULT`, `DEFAULT_DIV_VAL`, channel-count limit constant.
- Sub-module `clk_div_chan`: one channel (cnt/term/tick/level + priority logic); `clk_div_multi` is a generate loop over `CHANNELS` instances plus `div_val` slicing.

## Test plan
- Reset then `en`=1 on ch0, DEFAULT_DIV=200 → first tick after 201 edges, then every 201 cycles; `level` period 402, high 201.
- `load` ch1 with `div_val`=0, `en`=1 → tick high every cycle, level toggles every cycle.
- ch2 `term`=4, drop `en` for 3 cycles mid-count → tick interval 8 instead of 5; level holds during gap.
- ch3 `term`=9, pulse `clr` and `load`(`div_val`=2) same cycle at `cnt`=5 → clr wins: `cnt`=0, level=0, `term` stays 9.
- `load` asserted on the cycle `cnt`==`term` → no tick, level unchanged, next tick after new `term`+1 cycles.
- Assert `rst_n` low mid-count with level=1 → tick=0, level=0 without waiting for clk; `term` returns to 200.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and limits for the multi-channel clock divider
package clk_div_pkg;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int DEFAULT_DIV_VAL = 200;
    localparam int MAX_CHANNELS    = 16;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel producing a tick strobe and a 50%-duty level
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_level
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_term;
    logic             r_tick;
    logic             r_level;
    logic             w_hit;

    assign w_hit   = r_cnt == r_term;
    assign o_tick  = r_tick;
    assign o_level = r_level;

    // clr beats load beats en; a terminal count coincident with load is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_term  <= CNT_W'(DEFAULT_DIV);
            r_tick  <= 1'b0;
            r_level <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_level <= 1'b0;
        end else if (i_load) begin
            r_term  <= i_div;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else if (i_en) begin
            r_cnt   <= w_hit ? '0 : r_cnt + 1'b1;
            r_tick  <= w_hit;
            r_level <= r_level ^ w_hit;
        end else begin
            r_tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: array of independent clock-enable dividers with runtime divide values
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] div_val,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       level
);
    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en[g]),
            .i_clr  (clr[g]),
            .i_load (load[g]),
            .i_div  (div_val[g*CNT_W +: CNT_W]),
            .o_tick (tick[g]),
            .o_level(level[g])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed scenarios with an edge-indexed expectation scoreboard
module tb_clk_div_multi;
    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   en = '0, clr = '0, load = '0;
    logic [CH*W-1:0] div_val = '0;
    logic [CH-1:0]   tick, level;

    typedef struct {
        int    edge_n;
        int    ch;
        logic  tick;
        logic  level;
        string name;
    } exp_t;

    exp_t q[$];
    int   edges;
    int   n_vec = 0;
    int   n_bad = 0;
    int   t;

    clk_div_multi #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(200)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .load   (load),
        .div_val(div_val),
        .tick   (tick),
        .level  (level)
    );

    always #5 clk = ~clk;

    // edges = number of rising edges since reset was released
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic check(string name, int ch, logic et, logic el);
        n_vec++;
        if (tick[ch] !== et || level[ch] !== el) begin
            n_bad++;
            $display("FAIL %s ch%0d edge %0d: tick=%b level=%b, expected tick=%b level=%b",
                     name, ch, edges, tick[ch], level[ch], et, el);
        end
    endtask

    task automatic expect_at(int e, int ch, logic et, logic el, string name);
        exp_t x;
        x.edge_n = e; x.ch = ch; x.tick = et; x.level = el; x.name = name;
        q.push_back(x);
    endtask

    task automatic wait_to(int e);
        while (edges < e) @(negedge clk);
    endtask

    always @(negedge clk)
        if (rst_n)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].edge_n == edges) begin
                    check(q[i].name, q[i].ch, q[i].tick, q[i].level);
                    q.delete(i);
                end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < CH; i++) check("reset", i, 1'b0, 1'b0);
        // default divide of 200 on ch0
        expect_at(200, 0, 1'b0, 1'b0, "def_pre_tick");
        expect_at(201, 0, 1'b1, 1'b1, "def_first_tick");
        expect_at(202, 0, 1'b0, 1'b1, "def_after_tick");
        expect_at(401, 0, 1'b0, 1'b1, "def_level_high");
        expect_at(402, 0, 1'b1, 1'b0, "def_second_tick");
        expect_at(403, 0, 1'b0, 1'b0, "def_level_low");
        expect_at(603, 0, 1'b1, 1'b1, "def_third_tick");
        expect_at(604, 0, 1'b0, 1'b1, "def_idle_hold");
        expect_at(610, 0, 1'b0, 1'b1, "def_idle_hold2");
        en[0] = 1'b1;
        rst_n = 1'b1;
        wait_to(603);
        en[0] = 1'b0;
        // term = 0 on ch1
        t = edges;
        expect_at(t+1, 1, 1'b0, 1'b0, "div0_load");
        expect_at(t+2, 1, 1'b1, 1'b1, "div0_tick1");
        expect_at(t+3, 1, 1'b1, 1'b0, "div0_tick2");
        expect_at(t+4, 1, 1'b1, 1'b1, "div0_tick3");
        expect_at(t+5, 1, 1'b0, 1'b1, "div0_idle");
        load[1] = 1'b1;
        div_val[1*W +: W] = 16'd0;
        wait_to(t+1);
        load[1] = 1'b0;
        en[1] = 1'b1;
        wait_to(t+4);
        en[1] = 1'b0;
        wait_to(t+6);
        // term = 4 on ch2 with a 3-cycle enable gap
        t = edges;
        expect_at(t+6,  2, 1'b1, 1'b1, "gap_tick1");
        expect_at(t+7,  2, 1'b0, 1'b1, "gap_after");
        expect_at(t+10, 2, 1'b0, 1'b1, "gap_hold");
        expect_at(t+13, 2, 1'b0, 1'b1, "gap_late");
        expect_at(t+14, 2, 1'b1, 1'b0, "gap_tick2");
        expect_at(t+19, 2, 1'b1, 1'b1, "gap_tick3");
        load[2] = 1'b1;
        div_val[2*W +: W] = 16'd4;
        wait_to(t+1);
        load[2] = 1'b0;
        en[2] = 1'b1;
        wait_to(t+8);
        en[2] = 1'b0;
        wait_to(t+11);
        en[2] = 1'b1;
        wait_to(t+19);
        en[2] = 1'b0;
        wait_to(t+20);
        // ch3: clr vs load, load on terminal, async reset mid-count
        t = edges;
        expect_at(t+11, 3, 1'b1, 1'b1, "cl_tick1");
        expect_at(t+16, 3, 1'b0, 1'b1, "cl_pre_clr");
        expect_at(t+17, 3, 1'b0, 1'b0, "cl_cleared");
        expect_at(t+20, 3, 1'b0, 1'b0, "cl_term_kept");
        expect_at(t+26, 3, 1'b0, 1'b0, "cl_pre_tick");
        expect_at(t+27, 3, 1'b1, 1'b1, "cl_tick2");
        expect_at(t+37, 3, 1'b0, 1'b1, "ldterm_no_tick");
        expect_at(t+40, 3, 1'b0, 1'b1, "ldterm_pre");
        expect_at(t+41, 3, 1'b1, 1'b0, "ldterm_tick");
        expect_at(t+45, 3, 1'b1, 1'b1, "rst_pre_tick");
        expect_at(t+47, 3, 1'b0, 1'b1, "rst_pre_level");
        load[3] = 1'b1;
        div_val[3*W +: W] = 16'd9;
        wait_to(t+1);
        load[3] = 1'b0;
        en[3] = 1'b1;
        wait_to(t+16);
        clr[3] = 1'b1;
        load[3] = 1'b1;
        div_val[3*W +: W] = 16'd2;
        wait_to(t+17);
        clr[3] = 1'b0;
        load[3] = 1'b0;
        wait_to(t+36);
        load[3] = 1'b1;
        div_val[3*W +: W] = 16'd3;
        wait_to(t+37);
        load[3] = 1'b0;
        wait_to(t+47);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) check("async_rst", i, 1'b0, 1'b0);
        @(negedge clk);
        expect_at(200, 3, 1'b0, 1'b0, "rst_term_pre");
        expect_at(201, 3, 1'b1, 1'b1, "rst_term_tick");
        en = 4'b1000;
        rst_n = 1'b1;
        wait_to(202);
        foreach (q[i]) begin
            n_bad++;
            $display("FAIL %s ch%0d: expectation at edge %0d never checked", q[i].name, q[i].ch, q[i].edge_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
